// File: rtl/line_fill_unit_if.sv
// line_fill_unit_if
// Purpose : bundles the request side (instruction cache) and the word side
//           (memory bus) of the line fill unit into one connection.
// Modports:
//   slave  - the fill unit itself
//            in : addr_i, rd_i, mem_data_i, mem_ack_i
//            out: data_o, ack_o, mem_addr_o, mem_rd_o
//   master - whatever surrounds the unit (cache + memory, or a bench)
//            same signals with directions reversed
// Parameter LINE_BITS must match the unit it connects to.
interface line_fill_unit_if #(
  parameter int LINE_BITS = 256
);
  logic [31:0]          addr_i;
  logic                 rd_i;
  logic [LINE_BITS-1:0] data_o;
  logic                 ack_o;
  logic [31:0]          mem_addr_o;
  logic                 mem_rd_o;
  logic [31:0]          mem_data_i;
  logic                 mem_ack_i;

  modport slave (
    input  addr_i, rd_i, mem_data_i, mem_ack_i,
    output data_o, ack_o, mem_addr_o, mem_rd_o
  );

  modport master (
    output addr_i, rd_i, mem_data_i, mem_ack_i,
    input  data_o, ack_o, mem_addr_o, mem_rd_o
  );
endinterface

// File: rtl/line_fill_unit.sv
// line_fill_unit
// Purpose : fills one instruction cache line by issuing LINE_BITS/32 word
//           reads on the memory bus and assembling them into data_o; pulses
//           ack_o for one cycle once the whole line is present.
// Ports   :
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - line_fill_unit_if.slave
//          addr_i/rd_i       line request from the cache (held until ack_o)
//          data_o/ack_o      assembled line and completion pulse
//          mem_addr_o/mem_rd_o  word read request towards memory
//          mem_data_i/mem_ack_i word returned by memory
// Config  : define LINE_FILL_CRITICAL_FIRST_EN to start the fill at the word
//           addressed by addr_i and wrap around the line; otherwise the fill
//           always runs from word 0 upward.
module line_fill_unit #(
  parameter int LINE_BITS = 256
) (
  input  logic              clk,
  input  logic              rst,
  line_fill_unit_if.slave   bus
);

  localparam int WORDS = LINE_BITS / 32;
  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int IDX_W = $clog2(WORDS);

  localparam logic [IDX_W:0] LAST_CNT = (IDX_W + 1)'(WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [31:0]          base;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W:0]       cnt;
  logic [LINE_BITS-1:0] line;
  logic                 ack;
  logic                 mem_rd;
  logic [31:0]          mem_addr;

  logic [31:0]          req_base;
  logic [IDX_W-1:0]     start_idx;
  logic [IDX_W-1:0]     idx_next;
  logic                 unused_addr_bits;

  // The base has OFF low zero bits, so OR-ing in the word offset is an add.
  function automatic logic [31:0] word_addr(input logic [31:0] b,
                                            input logic [IDX_W-1:0] i);
    word_addr = b | (32'(i) << 2);
  endfunction

  always_comb begin
    req_base = {bus.addr_i[31:OFF], {OFF{1'b0}}};
`ifdef LINE_FILL_CRITICAL_FIRST_EN
    start_idx        = bus.addr_i[OFF-1:2];
    unused_addr_bits = ^bus.addr_i[1:0];
`else
    start_idx        = '0;
    unused_addr_bits = ^bus.addr_i[OFF-1:0];
`endif
    // WORDS is a power of two, so the natural overflow is the wrap to 0.
    idx_next = idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      idx      <= '0;
      cnt      <= '0;
      line     <= '0;
      ack      <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (bus.rd_i) begin
            base     <= req_base;
            idx      <= start_idx;
            cnt      <= '0;
            mem_rd   <= 1'b1;
            mem_addr <= word_addr(req_base, start_idx);
            state    <= FILL;
          end
        end
        FILL: begin
          // mem_rd is always high in FILL, so acks outside a fill never land.
          if (bus.mem_ack_i) begin
            line[{idx, 5'b00000} +: 32] <= bus.mem_data_i;
            idx <= idx_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              mem_rd <= 1'b0;
              ack    <= 1'b1;
              state  <= DONE;
            end else begin
              mem_addr <= word_addr(base, idx_next);
            end
          end
        end
        DONE: begin
          // Always passes through IDLE, so a held rd_i cannot restart here.
          ack   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_o     = line;
  assign bus.ack_o      = ack;
  assign bus.mem_addr_o = mem_addr;
  assign bus.mem_rd_o   = mem_rd;

endmodule

// File: tb/tb_line_fill_unit.sv
// tb_line_fill_unit
// Purpose : self-checking bench for line_fill_unit. A memory responder with
//           programmable wait states answers the word reads; a reference
//           model predicts the fetch order, completion cycle and final line.
// Ports   : none (top level)
// Config  : honours LINE_FILL_CRITICAL_FIRST_EN the same way as the design.
module tb_line_fill_unit;

  localparam int LINE_BITS = 256;
  localparam int WORDS     = LINE_BITS / 32;
  localparam int LINE_BYTES = LINE_BITS / 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  line_fill_unit_if #(.LINE_BITS(LINE_BITS)) bus ();

  line_fill_unit #(.LINE_BITS(LINE_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int check_count = 0;
  int pass_count  = 0;
  logic [511:0] last_line = '0;

  task automatic check_output(input string tag, input logic [511:0] obs,
                              input logic [511:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Memory contents: address scrambled by a per-fill salt (salt 0 = address).
  function automatic logic [31:0] mem_word(input logic [31:0] a,
                                           input logic [31:0] salt);
    return a ^ salt;
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a & ~(32'(LINE_BYTES) - 32'd1);
  endfunction

  function automatic int start_of(input logic [31:0] a);
`ifdef LINE_FILL_CRITICAL_FIRST_EN
    return int'((a % 32'(LINE_BYTES)) / 32'd4);
`else
    return 0;
`endif
  endfunction

  // k-th word the unit must request for a line request at address a.
  function automatic logic [31:0] nth_addr(input logic [31:0] a, input int k);
    return base_of(a) + 32'(4 * ((start_of(a) + k) % WORDS));
  endfunction

  function automatic logic [511:0] line_of(input logic [31:0] a,
                                           input logic [31:0] salt);
    logic [511:0] l;
    l = '0;
    for (int j = 0; j < WORDS; j++)
      l[j*32 +: 32] = mem_word(base_of(a) + 32'(4 * j), salt);
    return l;
  endfunction

  // One complete line request. wait_fixed < 0 picks random waits 0..3 per
  // word; abort_at >= 0 asserts rst on the edge that would take that word.
  task automatic apply_stimulus(input logic [31:0] addr, input int wait_fixed,
                                input logic [31:0] salt, input bit drop_rd,
                                input bit hold_rd, input int abort_at);
    int waits[WORDS];
    int n_acked;
    int wcnt;
    int cycle;
    logic [31:0] exp_addr;
    for (int k = 0; k < WORDS; k++)
      waits[k] = (wait_fixed < 0) ? int'($urandom_range(3)) : wait_fixed;
    @(negedge clk);
    rst = 1'b0;
    bus.addr_i = addr;
    bus.rd_i = 1'b1;
    bus.mem_ack_i = 1'b0;
    n_acked = 0;
    wcnt = 0;
    cycle = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (cycle > 200) begin
        check_output("fill_timeout", 512'(cycle), 512'(0));
        break;
      end
      if (n_acked < WORDS) begin
        exp_addr = nth_addr(addr, n_acked);
        check_output("fill_mem_rd", 512'(bus.mem_rd_o), 512'(1));
        check_output("fill_mem_addr", 512'(bus.mem_addr_o), 512'(exp_addr));
        check_output("fill_no_ack", 512'(bus.ack_o), 512'(0));
        bus.addr_i = $urandom;
        if (drop_rd && cycle == 2) bus.rd_i = 1'b0;
        if (wcnt == waits[n_acked]) begin
          bus.mem_ack_i = 1'b1;
          bus.mem_data_i = mem_word(exp_addr, salt);
          if (abort_at == n_acked) begin
            rst = 1'b1;
            @(negedge clk);
            check_output("abort_mem_rd", 512'(bus.mem_rd_o), 512'(0));
            check_output("abort_data", 512'(bus.data_o), 512'(0));
            check_output("abort_ack", 512'(bus.ack_o), 512'(0));
            check_output("abort_mem_addr", 512'(bus.mem_addr_o), 512'(0));
            rst = 1'b0;
            bus.rd_i = 1'b0;
            bus.mem_ack_i = 1'b0;
            last_line = '0;
            @(negedge clk);
            check_output("post_abort_ack", 512'(bus.ack_o), 512'(0));
            check_output("post_abort_rd", 512'(bus.mem_rd_o), 512'(0));
            return;
          end
          n_acked++;
          wcnt = 0;
        end else begin
          bus.mem_ack_i = 1'b0;
          bus.mem_data_i = $urandom;
          wcnt++;
        end
      end else begin
        check_output("done_ack", 512'(bus.ack_o), 512'(1));
        check_output("done_mem_rd", 512'(bus.mem_rd_o), 512'(0));
        check_output("done_line", 512'(bus.data_o), line_of(addr, salt));
        last_line = line_of(addr, salt);
        bus.mem_ack_i = 1'($urandom_range(1));
        bus.mem_data_i = $urandom;
        bus.rd_i = hold_rd;
        @(negedge clk);
        check_output("post_ack_low", 512'(bus.ack_o), 512'(0));
        check_output("post_ack_idle", 512'(bus.mem_rd_o), 512'(0));
        bus.rd_i = 1'b0;
        bus.mem_ack_i = 1'b0;
        break;
      end
    end
  endtask

  // Idle cycles with stray memory acks: nothing may start or change.
  task automatic idle_stray(input int n);
    bus.rd_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.mem_ack_i = 1'($urandom_range(1));
      bus.mem_data_i = $urandom;
      bus.addr_i = $urandom;
      @(negedge clk);
      check_output("idle_mem_rd", 512'(bus.mem_rd_o), 512'(0));
      check_output("idle_ack", 512'(bus.ack_o), 512'(0));
      check_output("idle_keep_line", 512'(bus.data_o), last_line);
    end
    bus.mem_ack_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.addr_i = 32'h0;
    bus.rd_i = 1'b0;
    bus.mem_data_i = 32'h0;
    bus.mem_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.rd_i = 1'b1;
    @(negedge clk);
    check_output("reset_ack", 512'(bus.ack_o), 512'(0));
    check_output("reset_mem_rd", 512'(bus.mem_rd_o), 512'(0));
    check_output("reset_mem_addr", 512'(bus.mem_addr_o), 512'(0));
    check_output("reset_data", 512'(bus.data_o), 512'(0));

    // Released into a pending request: must start on the first edge.
    apply_stimulus(32'h0000_1000, 0, 32'h0, 1'b0, 1'b0, -1);
    apply_stimulus(32'h0000_2014, 0, 32'h0, 1'b0, 1'b1, -1);
    apply_stimulus(32'h0000_3000, 3, 32'h5A5A_0000, 1'b0, 1'b0, -1);
    apply_stimulus(32'h0000_4008, 1, 32'h1234_5678, 1'b1, 1'b0, -1);
    idle_stray(4);
    apply_stimulus(32'h0000_5010, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3);
    apply_stimulus(32'h0000_6000, 0, 32'hCAFE_0000, 1'b0, 1'b0, -1);
    idle_stray(2);

    for (int t = 0; t < 20; t++) begin
      apply_stimulus($urandom, -1, $urandom, 1'($urandom_range(1)),
                     1'($urandom_range(1)),
                     ($urandom_range(7) == 0) ? int'($urandom_range(WORDS - 1)) : -1);
      idle_stray(int'($urandom_range(3)));
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/line_fill_unit.md
LINE_FILL_UNIT -- requirements
Module: line_fill_unit

Interface
REQ-001 SHALL have parameter LINE_BITS, default 256, cache line width in bits; legal values 64, 128, 256, 512; WORDS = LINE_BITS/32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port addr_i  input  32  line request address from instruction cache, stable while rd_i high.
REQ-005 SHALL have port rd_i  input  1  line read request, held until ack_o.
REQ-006 SHALL have port data_o  output  LINE_BITS  assembled line, word k at bits [32k+31:32k].
REQ-007 SHALL have port ack_o  output  1  one-cycle pulse, line complete.
REQ-008 SHALL have port mem_addr_o  output  32  word address to memory bus, bits [1:0] = 0.
REQ-009 SHALL have port mem_rd_o  output  1  word read request to memory bus.
REQ-010 SHALL have port mem_data_i  input  32  read word, valid when mem_ack_i high.
REQ-011 SHALL have port mem_ack_i  input  1  word accepted and data returned this cycle.

Function
REQ-012 SHALL implement states IDLE, FILL, DONE; all outputs registered.
REQ-013 IDLE: rd_i=1 at edge -> latch line base {addr_i[31:OFF], OFF zeros} (OFF = log2(LINE_BITS/8)), set start index, mem_rd_o=1, mem_addr_o=base+4*start, go FILL.
REQ-014 FILL: mem_rd_o held 1, mem_addr_o stable until mem_ack_i=1.
REQ-015 FILL, mem_ack_i=1: mem_data_i written to data_o word slot of current index; index incremented modulo WORDS (wraps to 0 after WORDS-1); received count incremented.
REQ-016 On the ack completing the WORDS-th word: mem_rd_o=0, go DONE; otherwise mem_addr_o updated to next index same edge, mem_rd_o stays 1 (back-to-back acks give one word per cycle).
REQ-017 DONE: ack_o=1 for exactly one cycle, data_o holds full line; next state IDLE unconditionally.
REQ-018 IDLE shall not accept a new request in the cycle ack_o is high; minimum one IDLE cycle between fills.
REQ-019 Latency with zero-wait memory: rd_i sampled at edge 0 -> mem_rd_o high cycles 1..WORDS -> ack_o high cycle WORDS+1.
REQ-020 rd_i deasserting during FILL shall be ignored; fill completes and ack_o still pulses.
REQ-021 addr_i changes during FILL/DONE shall not affect the fill.
REQ-022 data_o shall retain last completed line until next fill writes words; partially-filled data_o shall never be qualified by ack_o.
REQ-023 mem_ack_i while mem_rd_o=0 shall be ignored.

Reset
REQ-024 rst=1 at edge: state IDLE, ack_o=0, mem_rd_o=0, mem_addr_o=0, data_o=0, index and count 0.
REQ-025 rst mid-fill aborts immediately; no ack_o; in-flight memory word discarded.
REQ-026 First request accepted on first edge with rst=0 and rd_i=1.

Configuration
REQ-027 Macro LINE_FILL_CRITICAL_FIRST_EN defined: start index = addr_i[OFF-1:2], fetch order wraps (e.g. start 5 of 8: 5,6,7,0,1,2,3,4).
REQ-028 Macro undefined: start index = 0, order 0..WORDS-1, addr_i[OFF-1:0] ignored.
REQ-029 Either setting: data_o layout, latency, ack timing identical.

Verification
REQ-030 Zero-wait memory returning addr as data, rd_i with addr_i=0x0000_1000 -> mem_addr_o 0x1000..0x101C, ack_o at cycle 9, data_o word k = 0x1000+4k.
REQ-031 CRITICAL_FIRST_EN, addr_i=0x0000_2014 -> mem_addr_o order 0x2014,0x2018,0x201C,0x2000..0x2010; same data_o as aligned fill; without macro order starts 0x2000.
REQ-032 Memory with 3 wait cycles per word -> mem_addr_o stable during waits, ack_o at cycle 33, exactly 8 words captured.
REQ-033 rd_i dropped after cycle 2 of fill -> ack_o still single pulse at completion; stray mem_ack_i in IDLE -> no state change.
REQ-034 rst asserted at 4th word -> next cycle mem_rd_o=0, data_o=0, no ack_o; new request afterward completes normally.
